// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC controller for the RV32I fetch stage
module pc_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_cur,
  input  logic                  stall,
  input  logic                  br_taken,
  input  logic [ADDR_WIDTH-1:0] br_target,
  input  logic                  trap,
  input  logic [ADDR_WIDTH-1:0] trap_vec,
  input  logic                  mret,
  input  logic [ADDR_WIDTH-1:0] mepc,
  input  logic                  imem_ready,
  input  logic                  halt_req,
  output logic                  pc_en,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  fetch_valid,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  misalign_exc,
  output logic                  halted
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_WAIT   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic                  pend_valid, pend_valid_nxt;
  logic [ADDR_WIDTH-1:0] pend_addr, pend_addr_nxt;
  logic [1:0]            pend_prio, pend_prio_nxt;

  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_prio;
  logic                  req_chk;
  logic                  req_misalign;
  logic                  flush;

  assign flush_if_id = flush;
  assign flush_id_ex = flush;

  // Pick the highest-priority live redirect; trap vectors are trusted, others are alignment-checked
  always_comb begin
    req_valid = trap | mret | br_taken;
    req_addr  = '0;
    req_prio  = 2'd0;
    req_chk   = 1'b0;
    if (trap) begin
      req_addr = trap_vec;
      req_prio = 2'd3;
    end else if (mret) begin
      req_addr = mepc;
      req_prio = 2'd2;
      req_chk  = 1'b1;
    end else if (br_taken) begin
      req_addr = br_target;
      req_prio = 2'd1;
      req_chk  = 1'b1;
    end
    req_misalign = req_valid & req_chk & (req_addr[1:0] != 2'b00);
  end

  // Next-state, pending-buffer update and PC-control outputs
  always_comb begin
    state_nxt      = state;
    pend_valid_nxt = pend_valid;
    pend_addr_nxt  = pend_addr;
    pend_prio_nxt  = pend_prio;
    pc_en          = 1'b0;
    pc_next        = pc_cur;
    fetch_valid    = 1'b0;
    flush          = 1'b0;
    misalign_exc   = 1'b0;
    case (state)
      S_BOOT: begin
        pc_en     = 1'b1;
        pc_next   = RESET_VECTOR;
        flush     = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (req_valid) begin
          flush = 1'b1;
          if (req_misalign) begin
            misalign_exc = 1'b1;
          end else begin
            pc_en          = 1'b1;
            pc_next        = req_addr;
            pend_valid_nxt = 1'b0;
          end
        end else if (pend_valid) begin
          pc_en          = 1'b1;
          pc_next        = pend_addr;
          flush          = 1'b1;
          pend_valid_nxt = 1'b0;
        end else begin
          if (!stall && imem_ready) begin
            pc_en       = 1'b1;
            pc_next     = pc_cur + ADDR_WIDTH'(4);
            fetch_valid = 1'b1;
          end
          if (halt_req) begin
            state_nxt = S_HALTED;
          end else if (!stall && !imem_ready) begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (req_valid) begin
          flush = 1'b1;
          if (req_misalign) begin
            misalign_exc = 1'b1;
          end else if (!pend_valid || req_prio >= pend_prio) begin
            pend_valid_nxt = 1'b1;
            pend_addr_nxt  = req_addr;
            pend_prio_nxt  = req_prio;
          end
        end
        if (imem_ready) begin
          state_nxt = S_RUN;
        end
      end
      S_HALTED: begin
        if (trap) begin
          flush          = 1'b1;
          pend_valid_nxt = 1'b1;
          pend_addr_nxt  = trap_vec;
          pend_prio_nxt  = 2'd3;
        end
        if (!halt_req) begin
          state_nxt = S_RUN;
        end
      end
      default: begin
        state_nxt = S_BOOT;
      end
    endcase
  end

  // State, pending redirect buffer and halted flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_BOOT;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_prio  <= 2'd0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_valid <= pend_valid_nxt;
      pend_addr  <= pend_addr_nxt;
      pend_prio  <= pend_prio_nxt;
      halted     <= (state_nxt == S_HALTED);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_cur;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        trap = 1'b0;
  logic [31:0] trap_vec = 32'h80;
  logic        mret = 1'b0;
  logic [31:0] mepc = 32'h40;
  logic        imem_ready = 1'b1;
  logic        halt_req = 1'b0;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        fetch_valid;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        misalign_exc;
  logic        halted;

  typedef struct packed {
    logic        en;
    logic [31:0] nxt;
    logic        fv;
    logic        fi;
    logic        fe;
    logic        mis;
    logic        hlt;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  logic [31:0] pc_reg = 32'hDEAD_BEEF;

  assign pc_cur = pc_reg;

  pc_sequencer #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .trap(trap), .trap_vec(trap_vec),
    .mret(mret), .mepc(mepc), .imem_ready(imem_ready), .halt_req(halt_req),
    .pc_en(pc_en), .pc_next(pc_next), .fetch_valid(fetch_valid),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .misalign_exc(misalign_exc), .halted(halted)
  );

  always #5 clk = ~clk;

  // External PC register driven by the sequencer
  always @(posedge clk) begin
    if (pc_en === 1'b1) pc_reg <= pc_next;
  end

  task automatic cyc(input logic st, ir, hr, tr, mr, br, input logic [31:0] bt);
    @(negedge clk);
    stall = st; imem_ready = ir; halt_req = hr;
    trap = tr; mret = mr; br_taken = br; br_target = bt;
  endtask

  task automatic chk(input string tag, input logic en, input logic [31:0] nx,
                     input logic fv, fl, mis, hlt);
    exp_t e;
    exp_t o;
    e.en = en; e.nxt = nx; e.fv = fv; e.fi = fl; e.fe = fl; e.mis = mis; e.hlt = hlt;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    o.en = pc_en; o.nxt = pc_next; o.fv = fetch_valid; o.fi = flush_if_id;
    o.fe = flush_id_ex; o.mis = misalign_exc; o.hlt = halted;
    if (e.en !== 1'b1) begin
      o.nxt = '0;
      e.nxt = '0;
    end
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed en=%b nxt=%h fv=%b fi=%b fe=%b mis=%b hlt=%b expected en=%b nxt=%h fv=%b fi=%b fe=%b mis=%b hlt=%b",
             tag, o.en, o.nxt, o.fv, o.fi, o.fe, o.mis, o.hlt,
             e.en, e.nxt, e.fv, e.fi, e.fe, e.mis, e.hlt);
    end
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] exp_pc);
    compared++;
    assert (pc_reg === exp_pc) else begin
      mismatched++;
      $error("FAIL %s observed pc=%h expected pc=%h", tag, pc_reg, exp_pc);
    end
  endtask

  initial begin
    // reset and boot
    cyc(0,1,0,0,0,0,0); chk("boot_rst0", 1, 32'h0, 0, 1, 0, 0);
    cyc(0,1,0,0,0,0,0); rst = 1'b1; chk("boot_rst1", 1, 32'h0, 0, 1, 0, 0);
    cyc(0,1,0,0,0,0,0); chk_pc("first_pc", 32'h0); chk("seq4", 1, 32'h4, 1, 0, 0, 0);
    cyc(0,1,0,0,0,0,0); chk("seq8", 1, 32'h8, 1, 0, 0, 0);
    cyc(0,1,0,0,0,0,0); chk("seqc", 1, 32'hC, 1, 0, 0, 0);
    // branches
    cyc(0,1,0,0,0,1,32'h100); chk("br100", 1, 32'h100, 0, 1, 0, 0);
    cyc(0,1,0,0,0,1,32'h200); chk_pc("pc100", 32'h100); chk("br200", 1, 32'h200, 0, 1, 0, 0);
    cyc(0,1,0,0,0,0,0); chk_pc("pc200", 32'h200); chk("seq204", 1, 32'h204, 1, 0, 0, 0);
    // priority
    cyc(0,1,0,1,1,1,32'h300); chk("prio_trap", 1, 32'h80, 0, 1, 0, 0);
    cyc(0,1,0,0,1,1,32'h300); chk("prio_mret", 1, 32'h40, 0, 1, 0, 0);
    // stall
    cyc(1,1,0,0,0,0,0); chk("stall", 0, 32'h0, 0, 0, 0, 0);
    cyc(1,1,0,0,0,1,32'h300); chk("stall_br", 1, 32'h300, 0, 1, 0, 0);
    // memory wait with buffered branch
    cyc(0,0,0,0,0,0,0); chk("wait_enter", 0, 32'h0, 0, 0, 0, 0);
    cyc(0,0,0,0,0,1,32'h400); chk("wait_cap", 0, 32'h0, 0, 1, 0, 0);
    cyc(0,0,0,0,0,0,0); chk("wait_hold", 0, 32'h0, 0, 0, 0, 0);
    cyc(0,1,0,0,0,0,0); chk("wait_exit", 0, 32'h0, 0, 0, 0, 0);
    cyc(0,1,0,0,0,0,0); chk_pc("pc_wait", 32'h300); chk("pend_apply", 1, 32'h400, 0, 1, 0, 0);
    cyc(0,1,0,0,0,0,0); chk_pc("pc400", 32'h400); chk("seq404", 1, 32'h404, 1, 0, 0, 0);
    // pending priority overwrite
    mepc = 32'h600;
    cyc(0,0,0,0,0,0,0); chk("wait2", 0, 32'h0, 0, 0, 0, 0);
    cyc(0,0,0,0,0,1,32'h500); chk("cap500", 0, 32'h0, 0, 1, 0, 0);
    cyc(0,0,0,0,1,0,0); chk("cap_mret", 0, 32'h0, 0, 1, 0, 0);
    cyc(0,0,0,0,0,1,32'h700); chk("low_prio", 0, 32'h0, 0, 1, 0, 0);
    cyc(0,1,0,0,0,0,0); chk("exit2", 0, 32'h0, 0, 0, 0, 0);
    cyc(0,1,0,0,0,0,0); chk("pend600", 1, 32'h600, 0, 1, 0, 0);
    // misaligned target and wrap
    cyc(0,1,0,0,0,1,32'h202); chk_pc("pc600", 32'h600); chk("misalign", 0, 32'h0, 0, 1, 1, 0);
    cyc(0,1,0,0,0,0,0); chk_pc("pc_hold", 32'h600); chk("after_mis", 1, 32'h604, 1, 0, 0, 0);
    cyc(0,1,0,0,0,1,32'hFFFF_FFFC); chk("br_top", 1, 32'hFFFF_FFFC, 0, 1, 0, 0);
    cyc(0,1,0,0,0,0,0); chk("wrap", 1, 32'h0, 1, 0, 0, 0);
    // halt
    cyc(0,1,1,0,0,0,0); chk("halt_req", 1, 32'h4, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0,1,1,0,0,0,0); chk("halted", 0, 32'h0, 0, 0, 0, 1);
    end
    cyc(0,1,0,0,0,0,0); chk("halt_rel", 0, 32'h0, 0, 0, 0, 1);
    cyc(0,1,0,0,0,0,0); chk_pc("pc_halt", 32'h4); chk("resume", 1, 32'h8, 1, 0, 0, 0);
    cyc(0,1,1,0,0,0,0); chk("halt2", 1, 32'hC, 1, 0, 0, 0);
    cyc(0,1,1,1,0,0,0); chk("halt_trap", 0, 32'h0, 0, 1, 0, 1);
    cyc(0,1,0,0,0,0,0); chk("halt_rel2", 0, 32'h0, 0, 0, 0, 1);
    cyc(0,1,0,0,0,0,0); chk("trap_apply", 1, 32'h80, 0, 1, 0, 0);
    // reset mid-WAIT with pending valid
    cyc(0,0,0,0,0,0,0); chk("wait3", 0, 32'h0, 0, 0, 0, 0);
    cyc(0,0,0,0,0,1,32'h900); chk("cap900", 0, 32'h0, 0, 1, 0, 0);
    cyc(0,0,0,0,0,0,0); rst = 1'b0; chk("rst_wait", 0, 32'h0, 0, 0, 0, 0);
    cyc(0,1,0,0,0,0,0); rst = 1'b1; chk("boot2", 1, 32'h0, 0, 1, 0, 0);
    cyc(0,1,0,0,0,0,0); chk_pc("pc_boot2", 32'h0); chk("no_pend", 1, 32'h4, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
